// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction prefetch queue.
// The master drives fetched words and decode readiness; the slave is the queue itself.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] instr_in;
    logic [AW-1:0] pc_plus_1_in;
    logic          fetch_valid;
    logic          hlt;
    logic          flush;
    logic          dec_ready;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] pc_plus_1_out;
    logic          instr_valid;
    logic          stall_fetch;
    logic [CW-1:0] count;

    modport master (
        output instr_in, pc_plus_1_in, fetch_valid, hlt, flush, dec_ready,
        input  instr_out, pc_plus_1_out, instr_valid, stall_fetch, count
    );

    modport slave (
        input  instr_in, pc_plus_1_in, fetch_valid, hlt, flush, dec_ready,
        output instr_out, pc_plus_1_out, instr_valid, stall_fetch, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO: holds {instr, pc+1} pairs between IMEM fetch and decode,
// back-pressures the PC when full and discards wrong-path entries on flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          full, empty, push, pop;

    logic [DW-1:0] entry_instr [DEPTH];
    logic [AW-1:0] entry_pc    [DEPTH];

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // A flushing cycle neither accepts the wrong-path fetch nor hands anything to decode.
    assign push = fq.fetch_valid && !fq.hlt && !fq.flush && !full;
    assign pop  = !empty && fq.dec_ready && !fq.flush;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (fq.flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DW-1:0] instr_reg;
            logic [AW-1:0] pc_reg;

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    instr_reg <= fq.instr_in;
                    pc_reg    <= fq.pc_plus_1_in;
                end
            end

            assign entry_instr[gi] = instr_reg;
            assign entry_pc[gi]    = pc_reg;
        end
    endgenerate

    assign fq.instr_valid   = !empty;
    assign fq.stall_fetch   = full;
    assign fq.count         = count_reg;
    assign fq.instr_out     = empty ? '0 : entry_instr[rd_ptr_reg];
    assign fq.pc_plus_1_out = empty ? '0 : entry_pc[rd_ptr_reg];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/back-pressure, streaming, flush,
// halted drain and reset while full, each with hand-computed expectations.
module tb_fetch_queue;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_queue_if #(.DEPTH(4), .DW(16), .AW(16)) fq_bus ();

    fetch_queue #(.DEPTH(4), .DW(16), .AW(16)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b fv=%b in=%h hlt=%b fl=%b rdy=%b -> cnt=%0d vld=%b stall=%b out=%h pc=%h",
                 $time, rst, fq_bus.fetch_valid, fq_bus.instr_in, fq_bus.hlt, fq_bus.flush,
                 fq_bus.dec_ready, fq_bus.count, fq_bus.instr_valid, fq_bus.stall_fetch,
                 fq_bus.instr_out, fq_bus.pc_plus_1_out);
    endtask

    task automatic idle_inputs();
        fq_bus.instr_in     = 16'h0000;
        fq_bus.pc_plus_1_in = 16'h0000;
        fq_bus.fetch_valid  = 1'b0;
        fq_bus.hlt          = 1'b0;
        fq_bus.flush        = 1'b0;
        fq_bus.dec_ready    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (fq_bus.count !== 3'd0) begin failures++; $display("FAIL reset_count act=%0d exp=0", fq_bus.count); end
        checks++; if (fq_bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid act=%b exp=0", fq_bus.instr_valid); end
        checks++; if (fq_bus.stall_fetch !== 1'b0) begin failures++; $display("FAIL reset_stall act=%b exp=0", fq_bus.stall_fetch); end
        checks++; if (fq_bus.instr_out !== 16'h0000) begin failures++; $display("FAIL reset_instr act=%h exp=0000", fq_bus.instr_out); end
        checks++; if (fq_bus.pc_plus_1_out !== 16'h0000) begin failures++; $display("FAIL reset_pc act=%h exp=0000", fq_bus.pc_plus_1_out); end
        // dec_ready on an empty queue must not underflow
        fq_bus.dec_ready = 1'b1;
        tick();
        checks++; if (fq_bus.count !== 3'd0) begin failures++; $display("FAIL empty_pop_count act=%0d exp=0", fq_bus.count); end
        idle_inputs();
    endtask

    task automatic test_fill_backpressure();
        fq_bus.dec_ready   = 1'b0;
        fq_bus.fetch_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            fq_bus.instr_in     = 16'hA000 + 16'(i);
            fq_bus.pc_plus_1_in = 16'(i);
            tick();
            checks++; if (fq_bus.count !== 3'(i)) begin failures++; $display("FAIL fill_count[%0d] act=%0d exp=%0d", i, fq_bus.count, i); end
        end
        checks++; if (fq_bus.stall_fetch !== 1'b1) begin failures++; $display("FAIL fill_stall act=%b exp=1", fq_bus.stall_fetch); end
        checks++; if (fq_bus.instr_out !== 16'hA001) begin failures++; $display("FAIL fill_head act=%h exp=a001", fq_bus.instr_out); end
        // word presented while full is dropped
        fq_bus.instr_in     = 16'hA005;
        fq_bus.pc_plus_1_in = 16'h0005;
        tick();
        checks++; if (fq_bus.count !== 3'd4) begin failures++; $display("FAIL full_drop_count act=%0d exp=4", fq_bus.count); end
        checks++; if (fq_bus.instr_out !== 16'hA001) begin failures++; $display("FAIL full_drop_head act=%h exp=a001", fq_bus.instr_out); end
        // one pop frees a slot; the push waits for the following edge
        fq_bus.dec_ready = 1'b1;
        tick();
        checks++; if (fq_bus.count !== 3'd3) begin failures++; $display("FAIL pop_full_count act=%0d exp=3", fq_bus.count); end
        checks++; if (fq_bus.stall_fetch !== 1'b0) begin failures++; $display("FAIL pop_full_stall act=%b exp=0", fq_bus.stall_fetch); end
        checks++; if (fq_bus.instr_out !== 16'hA002) begin failures++; $display("FAIL pop_full_head act=%h exp=a002", fq_bus.instr_out); end
        fq_bus.dec_ready = 1'b0;
        tick();
        checks++; if (fq_bus.count !== 3'd4) begin failures++; $display("FAIL repush_count act=%0d exp=4", fq_bus.count); end
        checks++; if (fq_bus.stall_fetch !== 1'b1) begin failures++; $display("FAIL repush_stall act=%b exp=1", fq_bus.stall_fetch); end
        fq_bus.fetch_valid = 1'b0;
        fq_bus.dec_ready   = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            checks++; if (fq_bus.instr_out !== 16'hA000 + 16'(i)) begin failures++; $display("FAIL drain_instr[%0d] act=%h exp=%h", i, fq_bus.instr_out, 16'hA000 + 16'(i)); end
            checks++; if (fq_bus.pc_plus_1_out !== 16'(i)) begin failures++; $display("FAIL drain_pc[%0d] act=%h exp=%h", i, fq_bus.pc_plus_1_out, 16'(i)); end
            tick();
        end
        checks++; if (fq_bus.count !== 3'd0) begin failures++; $display("FAIL drain_count act=%0d exp=0", fq_bus.count); end
        idle_inputs();
    endtask

    task automatic test_streaming();
        fq_bus.fetch_valid = 1'b1;
        fq_bus.dec_ready   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fq_bus.instr_in     = 16'hB000 + 16'(i);
            fq_bus.pc_plus_1_in = 16'h0100 + 16'(i);
            tick();
            checks++; if (fq_bus.count !== 3'd1) begin failures++; $display("FAIL stream_count[%0d] act=%0d exp=1", i, fq_bus.count); end
            checks++; if (fq_bus.instr_out !== 16'hB000 + 16'(i)) begin failures++; $display("FAIL stream_instr[%0d] act=%h exp=%h", i, fq_bus.instr_out, 16'hB000 + 16'(i)); end
            checks++; if (fq_bus.pc_plus_1_out !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL stream_pc[%0d] act=%h exp=%h", i, fq_bus.pc_plus_1_out, 16'h0100 + 16'(i)); end
        end
        fq_bus.fetch_valid = 1'b0;
        tick();
        checks++; if (fq_bus.count !== 3'd0) begin failures++; $display("FAIL stream_end_count act=%0d exp=0", fq_bus.count); end
        idle_inputs();
    endtask

    task automatic test_flush();
        fq_bus.fetch_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            fq_bus.instr_in     = 16'hE000 + 16'(i);
            fq_bus.pc_plus_1_in = 16'h0300 + 16'(i);
            tick();
        end
        checks++; if (fq_bus.count !== 3'd3) begin failures++; $display("FAIL flush_pre_count act=%0d exp=3", fq_bus.count); end
        fq_bus.flush        = 1'b1;
        fq_bus.instr_in     = 16'hDEAD;
        fq_bus.pc_plus_1_in = 16'h0400;
        fq_bus.dec_ready    = 1'b1;
        tick();
        checks++; if (fq_bus.count !== 3'd0) begin failures++; $display("FAIL flush_count act=%0d exp=0", fq_bus.count); end
        checks++; if (fq_bus.instr_valid !== 1'b0) begin failures++; $display("FAIL flush_valid act=%b exp=0", fq_bus.instr_valid); end
        checks++; if (fq_bus.instr_out !== 16'h0000) begin failures++; $display("FAIL flush_instr act=%h exp=0000", fq_bus.instr_out); end
        fq_bus.flush        = 1'b0;
        fq_bus.dec_ready    = 1'b0;
        fq_bus.instr_in     = 16'hC000;
        fq_bus.pc_plus_1_in = 16'h0200;
        tick();
        checks++; if (fq_bus.count !== 3'd1) begin failures++; $display("FAIL post_flush_count act=%0d exp=1", fq_bus.count); end
        checks++; if (fq_bus.instr_out !== 16'hC000) begin failures++; $display("FAIL post_flush_instr act=%h exp=c000", fq_bus.instr_out); end
        checks++; if (fq_bus.pc_plus_1_out !== 16'h0200) begin failures++; $display("FAIL post_flush_pc act=%h exp=0200", fq_bus.pc_plus_1_out); end
        fq_bus.fetch_valid = 1'b0;
        fq_bus.dec_ready   = 1'b1;
        tick();
        checks++; if (fq_bus.count !== 3'd0) begin failures++; $display("FAIL post_flush_drain act=%0d exp=0", fq_bus.count); end
        idle_inputs();
    endtask

    task automatic test_hlt_drain();
        fq_bus.fetch_valid = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            fq_bus.instr_in     = 16'hF000 + 16'(i);
            fq_bus.pc_plus_1_in = 16'h0500 + 16'(i);
            tick();
        end
        fq_bus.hlt          = 1'b1;
        fq_bus.dec_ready    = 1'b1;
        fq_bus.instr_in     = 16'h7777;
        fq_bus.pc_plus_1_in = 16'h0777;
        checks++; if (fq_bus.instr_out !== 16'hF001) begin failures++; $display("FAIL hlt_head0 act=%h exp=f001", fq_bus.instr_out); end
        tick();
        checks++; if (fq_bus.count !== 3'd1) begin failures++; $display("FAIL hlt_count1 act=%0d exp=1", fq_bus.count); end
        checks++; if (fq_bus.instr_out !== 16'hF002) begin failures++; $display("FAIL hlt_head1 act=%h exp=f002", fq_bus.instr_out); end
        tick();
        checks++; if (fq_bus.count !== 3'd0) begin failures++; $display("FAIL hlt_count0 act=%0d exp=0", fq_bus.count); end
        checks++; if (fq_bus.instr_valid !== 1'b0) begin failures++; $display("FAIL hlt_valid act=%b exp=0", fq_bus.instr_valid); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        fq_bus.fetch_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            fq_bus.instr_in     = 16'h9000 + 16'(i);
            fq_bus.pc_plus_1_in = 16'h0600 + 16'(i);
            tick();
        end
        checks++; if (fq_bus.stall_fetch !== 1'b1) begin failures++; $display("FAIL mid_pre_stall act=%b exp=1", fq_bus.stall_fetch); end
        rst              = 1'b1;
        fq_bus.dec_ready = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (fq_bus.count !== 3'd0) begin failures++; $display("FAIL mid_rst_count act=%0d exp=0", fq_bus.count); end
        checks++; if (fq_bus.instr_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid act=%b exp=0", fq_bus.instr_valid); end
        checks++; if (fq_bus.stall_fetch !== 1'b0) begin failures++; $display("FAIL mid_rst_stall act=%b exp=0", fq_bus.stall_fetch); end
        checks++; if (fq_bus.instr_out !== 16'h0000) begin failures++; $display("FAIL mid_rst_instr act=%h exp=0000", fq_bus.instr_out); end
        checks++; if (fq_bus.pc_plus_1_out !== 16'h0000) begin failures++; $display("FAIL mid_rst_pc act=%h exp=0000", fq_bus.pc_plus_1_out); end
        fq_bus.dec_ready    = 1'b0;
        fq_bus.instr_in     = 16'h1234;
        fq_bus.pc_plus_1_in = 16'h0042;
        tick();
        checks++; if (fq_bus.count !== 3'd1) begin failures++; $display("FAIL mid_push_count act=%0d exp=1", fq_bus.count); end
        checks++; if (fq_bus.instr_out !== 16'h1234) begin failures++; $display("FAIL mid_push_instr act=%h exp=1234", fq_bus.instr_out); end
        checks++; if (fq_bus.pc_plus_1_out !== 16'h0042) begin failures++; $display("FAIL mid_push_pc act=%h exp=0042", fq_bus.pc_plus_1_out); end
        fq_bus.fetch_valid = 1'b0;
        fq_bus.dec_ready   = 1'b1;
        tick();
        checks++; if (fq_bus.count !== 3'd0) begin failures++; $display("FAIL mid_final_count act=%0d exp=0", fq_bus.count); end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_fill_backpressure();
        test_streaming();
        test_flush();
        test_hlt_drain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
